// File: rtl/ledr_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ledr_sequencer_pkg
// Shared definitions for the red-LED sequencer: register addresses on the
// Avalon-MM slave port, mode encodings held in CONTROL[1:0], and the bit
// positions of the remaining CONTROL and STATUS fields.
// ---------------------------------------------------------------------------
package ledr_sequencer_pkg;

    localparam logic [1:0] ADDR_PATTERN = 2'd0;
    localparam logic [1:0] ADDR_CONTROL = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_MIRROR = 2'd3
    } mode_e;

    localparam int CTRL_MODE_LSB   = 0;
    localparam int CTRL_ENABLE_BIT = 2;
    localparam int CTRL_DIR_BIT    = 3;
    localparam int STATUS_STEP_LSB = 16;

endpackage

// File: rtl/ledr_sequencer_if.sv
// ---------------------------------------------------------------------------
// ledr_sequencer_if
// Avalon-MM register bus used by the LED sequencer.
//   address    : register select
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : combinational read data, zero wait states
// master drives the request side, slave returns readdata.
// ---------------------------------------------------------------------------
interface ledr_sequencer_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/ledr_prescaler.sv
// ---------------------------------------------------------------------------
// ledr_prescaler
// Step-timing prescaler. Counts 0..max(period,1)-1 while run is high and
// emits a one-cycle tick on the last count.
//   clk, reset_n : clock, asynchronous active-low reset
//   period       : cycles per step (0 behaves as 1)
//   run          : count enable; counter is held at 0 while low
//   restart      : forces the counter back to 0 and suppresses tick
//   tick         : one-cycle step pulse
// ---------------------------------------------------------------------------
module ledr_prescaler #(
    parameter int PRESCALE_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [PRESCALE_WIDTH-1:0] period,
    input  logic                      run,
    input  logic                      restart,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] cnt;
    logic [PRESCALE_WIDTH-1:0] last;

    // A zero period is treated as one, so the last count is 0 in both cases.
    assign last = (period == '0) ? '0 : period - PRESCALE_WIDTH'(1);
    assign tick = run & ~restart & (cnt == last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!run || restart || (cnt == last)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESCALE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/ledr_sequencer.sv
// ---------------------------------------------------------------------------
// ledr_sequencer
// Avalon-MM controlled sequencer for the red LED bank. Modes: static
// pattern, blink, rotating chase, or a live mirror of hw_pattern. A
// programmable prescaler sets the step rate for blink and chase.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   hw_pattern   : status vector shown in MIRROR mode
//   out_port     : registered LED drive
// Registers: 0 PATTERN, 1 CONTROL {dir,enable,mode}, 2 PERIOD,
//            3 STATUS {step_cnt[31:16], out_port} (write clears step_cnt).
// ---------------------------------------------------------------------------
module ledr_sequencer
    import ledr_sequencer_pkg::*;
#(
    parameter int          LED_WIDTH      = 10,
    parameter int          PRESCALE_WIDTH = 24,
    parameter int unsigned DEFAULT_PERIOD = 5000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ledr_sequencer_if.slave      bus,
    input  logic [LED_WIDTH-1:0] hw_pattern,
    output logic [LED_WIDTH-1:0] out_port
);

    logic [LED_WIDTH-1:0]      pattern_r;
    mode_e                     mode_r;
    logic                      enable_r;
    logic                      dir_r;
    logic [PRESCALE_WIDTH-1:0] period_r;
    logic                      phase_r;
    logic [LED_WIDTH-1:0]      shift_r;
    logic [15:0]               step_cnt;

    logic                      we;
    logic                      wr_pattern;
    logic                      wr_control;
    logic                      wr_period;
    logic                      wr_status;
    logic                      restart;
    logic                      run;
    logic                      tick;
    logic [LED_WIDTH-1:0]      pattern_next;
    logic [31:0]               rdata;
    logic                      unused_wdata;

    // dir=0 rotates toward the MSB, dir=1 toward the LSB.
    function automatic logic [LED_WIDTH-1:0] rotate(input logic [LED_WIDTH-1:0] v,
                                                   input logic dir);
        if (dir) begin
            return {v[0], v[LED_WIDTH-1:1]};
        end
        return {v[LED_WIDTH-2:0], v[LED_WIDTH-1]};
    endfunction

    assign we         = bus.chipselect & ~bus.write_n;
    assign wr_pattern = we & (bus.address == ADDR_PATTERN);
    assign wr_control = we & (bus.address == ADDR_CONTROL);
    assign wr_period  = we & (bus.address == ADDR_PERIOD);
    assign wr_status  = we & (bus.address == ADDR_STATUS);
    assign restart    = wr_control | wr_period;
    assign run        = enable_r & ((mode_r == MODE_BLINK) | (mode_r == MODE_CHASE));

    assign pattern_next = wr_pattern ? bus.writedata[LED_WIDTH-1:0] : pattern_r;

    // Bits outside the defined fields are intentionally dropped.
    assign unused_wdata = ^bus.writedata;

    ledr_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_r),
        .run     (run),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_r <= '0;
            mode_r    <= MODE_STATIC;
            enable_r  <= 1'b0;
            dir_r     <= 1'b0;
            period_r  <= PRESCALE_WIDTH'(DEFAULT_PERIOD);
            phase_r   <= 1'b1;
            shift_r   <= '0;
            step_cnt  <= '0;
            out_port  <= '0;
        end else begin
            pattern_r <= pattern_next;

            if (wr_control) begin
                mode_r   <= mode_e'(bus.writedata[CTRL_MODE_LSB +: 2]);
                enable_r <= bus.writedata[CTRL_ENABLE_BIT];
                dir_r    <= bus.writedata[CTRL_DIR_BIT];
            end

            if (wr_period) begin
                period_r <= bus.writedata[PRESCALE_WIDTH-1:0];
            end

            if (restart) begin
                phase_r <= 1'b1;
            end else if (tick && (mode_r == MODE_BLINK)) begin
                phase_r <= ~phase_r;
            end

            // A register write reloads the shifter and drops a coincident rotate.
            if (restart || wr_pattern) begin
                shift_r <= pattern_next;
            end else if (tick && (mode_r == MODE_CHASE)) begin
                shift_r <= rotate(shift_r, dir_r);
            end

            // A clear beats a coincident increment.
            if (wr_status) begin
                step_cnt <= '0;
            end else if (tick) begin
                step_cnt <= step_cnt + 16'd1;
            end

            if (!enable_r) begin
                out_port <= '0;
            end else begin
                case (mode_r)
                    MODE_STATIC: out_port <= pattern_r;
                    MODE_BLINK:  out_port <= phase_r ? pattern_r : '0;
                    MODE_CHASE:  out_port <= shift_r;
                    MODE_MIRROR: out_port <= hw_pattern;
                    default:     out_port <= '0;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_PATTERN: rdata[LED_WIDTH-1:0] = pattern_r;
            ADDR_CONTROL: rdata[3:0] = {dir_r, enable_r, mode_r};
            ADDR_PERIOD:  rdata[PRESCALE_WIDTH-1:0] = period_r;
            ADDR_STATUS: begin
                rdata[LED_WIDTH-1:0]          = out_port;
                rdata[STATUS_STEP_LSB +: 16]  = step_cnt;
            end
            default:      rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;

endmodule

// File: tb/tb_ledr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ledr_sequencer
// Directed bench for ledr_sequencer with DEFAULT_PERIOD overridden to 4.
// Inputs change on the falling edge; outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_ledr_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  hw_pattern;
    logic [9:0]  out_port;
    logic [31:0] rd_val;
    int          checks = 0;
    int          errors = 0;

    ledr_sequencer_if bus ();

    ledr_sequencer #(
        .LED_WIDTH      (10),
        .PRESCALE_WIDTH (24),
        .DEFAULT_PERIOD (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .hw_pattern (hw_pattern),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One write cycle; called at a falling edge, returns at the next one.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    task automatic test_reset;
        reset_n        = 1'b0;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        hw_pattern     = 10'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (out_port !== 10'h000) begin
            errors++; $display("FAIL reset_out: got %h expected %h", out_port, 10'h000);
        end
        rd(2'd2, rd_val); checks++;
        if (rd_val !== 32'd4) begin
            errors++; $display("FAIL reset_period: got %h expected %h", rd_val, 32'd4);
        end
        rd(2'd1, rd_val); checks++;
        if (rd_val !== 32'd0) begin
            errors++; $display("FAIL reset_control: got %h expected %h", rd_val, 32'd0);
        end
        rd(2'd3, rd_val); checks++;
        if (rd_val !== 32'd0) begin
            errors++; $display("FAIL reset_status: got %h expected %h", rd_val, 32'd0);
        end
        rd(2'd0, rd_val); checks++;
        if (rd_val !== 32'd0) begin
            errors++; $display("FAIL reset_pattern: got %h expected %h", rd_val, 32'd0);
        end
    endtask

    task automatic test_static;
        wr(2'd0, 32'h0000_02A5);
        checks++;
        if (out_port !== 10'h000) begin
            errors++; $display("FAIL static_disabled: got %h expected %h", out_port, 10'h000);
        end
        wr(2'd0, 32'hFFFF_FEA5);
        rd(2'd0, rd_val); checks++;
        if (rd_val !== 32'h0000_02A5) begin
            errors++; $display("FAIL pattern_field: got %h expected %h", rd_val, 32'h0000_02A5);
        end
        wr(2'd1, 32'hFFFF_FFF4);
        @(negedge clk);
        checks++;
        if (out_port !== 10'h2A5) begin
            errors++; $display("FAIL static_out: got %h expected %h", out_port, 10'h2A5);
        end
        rd(2'd3, rd_val); checks++;
        if (rd_val !== 32'h0000_02A5) begin
            errors++; $display("FAIL static_status: got %h expected %h", rd_val, 32'h0000_02A5);
        end
        rd(2'd1, rd_val); checks++;
        if (rd_val !== 32'h0000_0004) begin
            errors++; $display("FAIL control_field: got %h expected %h", rd_val, 32'h0000_0004);
        end
    endtask

    task automatic test_blink;
        logic [9:0] exp;
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h3FF);
        wr(2'd1, 32'h5);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            exp = ((((i - 1) / 4) % 2) == 0) ? 10'h3FF : 10'h000;
            checks++;
            if (out_port !== exp) begin
                errors++; $display("FAIL blink_step%0d: got %h expected %h", i, out_port, exp);
            end
        end
        rd(2'd3, rd_val); checks++;
        if (rd_val !== 32'h0003_03FF) begin
            errors++; $display("FAIL blink_stepcnt: got %h expected %h", rd_val, 32'h0003_03FF);
        end
        wr(2'd3, 32'd0);
        rd(2'd3, rd_val); checks++;
        if (rd_val[31:16] !== 16'd0) begin
            errors++; $display("FAIL step_clear: got %h expected %h", rd_val[31:16], 16'd0);
        end
        repeat (2) @(negedge clk);
        wr(2'd3, 32'd0);
        rd(2'd3, rd_val); checks++;
        if (rd_val[31:16] !== 16'd0) begin
            errors++; $display("FAIL clear_on_tick: got %h expected %h", rd_val[31:16], 16'd0);
        end
        repeat (4) @(negedge clk);
        rd(2'd3, rd_val); checks++;
        if (rd_val[31:16] !== 16'd1) begin
            errors++; $display("FAIL step_after_clear: got %h expected %h", rd_val[31:16], 16'd1);
        end
    endtask

    task automatic test_chase;
        logic [9:0] exp;
        wr(2'd2, 32'd2);
        wr(2'd0, 32'h001);
        wr(2'd1, 32'h6);
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            exp = 10'h001 << (((i - 1) / 2) % 10);
            checks++;
            if (out_port !== exp) begin
                errors++; $display("FAIL chase_up%0d: got %h expected %h", i, out_port, exp);
            end
        end
        wr(2'd1, 32'hE);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp = 10'h001;
            for (int k = 0; k < (i - 1) / 2; k++) exp = {exp[0], exp[9:1]};
            checks++;
            if (out_port !== exp) begin
                errors++; $display("FAIL chase_down%0d: got %h expected %h", i, out_port, exp);
            end
        end
    endtask

    task automatic test_pattern_on_tick;
        logic [9:0] exp;
        wr(2'd1, 32'h6);
        @(negedge clk);
        wr(2'd0, 32'h010);
        @(negedge clk); checks++;
        if (out_port !== 10'h010) begin
            errors++; $display("FAIL tick_load_a: got %h expected %h", out_port, 10'h010);
        end
        @(negedge clk); checks++;
        if (out_port !== 10'h010) begin
            errors++; $display("FAIL tick_load_b: got %h expected %h", out_port, 10'h010);
        end
        @(negedge clk); checks++;
        if (out_port !== 10'h020) begin
            errors++; $display("FAIL tick_load_next: got %h expected %h", out_port, 10'h020);
        end
        wr(2'd2, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            exp = 10'h010 << (i - 1);
            checks++;
            if (out_port !== exp) begin
                errors++; $display("FAIL period0_%0d: got %h expected %h", i, out_port, exp);
            end
        end
    endtask

    task automatic test_mirror;
        wr(2'd1, 32'h7);
        hw_pattern = 10'h155;
        @(negedge clk); checks++;
        if (out_port !== 10'h155) begin
            errors++; $display("FAIL mirror_a: got %h expected %h", out_port, 10'h155);
        end
        hw_pattern = 10'h0AA;
        #1; checks++;
        if (out_port !== 10'h155) begin
            errors++; $display("FAIL mirror_lag: got %h expected %h", out_port, 10'h155);
        end
        @(negedge clk); checks++;
        if (out_port !== 10'h0AA) begin
            errors++; $display("FAIL mirror_b: got %h expected %h", out_port, 10'h0AA);
        end
        wr(2'd1, 32'h3);
        @(negedge clk); checks++;
        if (out_port !== 10'h000) begin
            errors++; $display("FAIL mirror_disabled: got %h expected %h", out_port, 10'h000);
        end
    endtask

    task automatic test_reset_mid;
        wr(2'd2, 32'd2);
        wr(2'd0, 32'h3FF);
        wr(2'd1, 32'h5);
        repeat (6) @(negedge clk);
        checks++;
        if (out_port !== 10'h3FF) begin
            errors++; $display("FAIL pre_reset_out: got %h expected %h", out_port, 10'h3FF);
        end
        #2;
        reset_n = 1'b0;
        #1; checks++;
        if (out_port !== 10'h000) begin
            errors++; $display("FAIL async_reset_out: got %h expected %h", out_port, 10'h000);
        end
        rd(2'd0, rd_val); checks++;
        if (rd_val !== 32'd0) begin
            errors++; $display("FAIL mid_reset_pattern: got %h expected %h", rd_val, 32'd0);
        end
        rd(2'd1, rd_val); checks++;
        if (rd_val !== 32'd0) begin
            errors++; $display("FAIL mid_reset_control: got %h expected %h", rd_val, 32'd0);
        end
        rd(2'd2, rd_val); checks++;
        if (rd_val !== 32'd4) begin
            errors++; $display("FAIL mid_reset_period: got %h expected %h", rd_val, 32'd4);
        end
        rd(2'd3, rd_val); checks++;
        if (rd_val !== 32'd0) begin
            errors++; $display("FAIL mid_reset_status: got %h expected %h", rd_val, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); checks++;
        if (out_port !== 10'h000) begin
            errors++; $display("FAIL post_reset_out: got %h expected %h", out_port, 10'h000);
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_blink();
        test_chase();
        test_pattern_on_tick();
        test_mirror();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
